// File: rtl/booth_mul_param.sv
// booth_mul_param: iterative radix-4 Booth multiplier, signed or unsigned operands.
// Rev 1.0 -- initial release.
`default_nettype none

module booth_mul_param #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic [2*WIDTH-1:0]   z,
  output logic                 busy,
  output logic                 done
);

  localparam int N  = WIDTH / 2 + 1;
  localparam int E  = WIDTH + 2;           // extended operand width
  localparam int A  = E + 2;               // accumulator width, holds +-2X plus carry-in history
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [A-1:0] mul_px, mul_nx, mul_p2x, mul_n2x;
  logic signed [A-1:0] acc;
  logic [E-1:0]        mq;
  logic                q_prev;
  logic [CW-1:0]       cnt;

  logic                accept;
  logic                last_iter;
  logic [E-1:0]        x_ext, y_ext;
  logic signed [A-1:0] x_acc;
  logic [2:0]          group;
  logic signed [A-1:0] addend;
  logic signed [A-1:0] sum;
  logic signed [A-1:0] acc_nxt;
  logic [E-1:0]        mq_nxt;
  logic [2*WIDTH-1:0]  z_nxt;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_iter = (state == CALC) && (cnt == LAST);

  assign x_ext = signed_mode ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
  assign y_ext = signed_mode ? {{2{y[WIDTH-1]}}, y} : {2'b00, y};
  assign x_acc = {{2{x_ext[E-1]}}, x_ext};

  assign group = {mq[1:0], q_prev};

  always_comb begin
    addend = '0;
    case (group)
      3'b001, 3'b010: addend = mul_px;
      3'b011:         addend = mul_p2x;
      3'b100:         addend = mul_n2x;
      3'b101, 3'b110: addend = mul_nx;
      default:        addend = '0;
    endcase
  end

  // The two bits shifted out of the accumulator become the next product bits in mq.
  assign sum     = acc + addend;
  assign acc_nxt = {{2{sum[A-1]}}, sum[A-1:2]};
  assign mq_nxt  = {sum[1:0], mq[E-1:2]};
  assign z_nxt   = {acc_nxt[WIDTH-3:0], mq_nxt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_px  <= '0;
      mul_nx  <= '0;
      mul_p2x <= '0;
      mul_n2x <= '0;
      acc     <= '0;
      mq      <= '0;
      q_prev  <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      mul_px  <= x_acc;
      mul_nx  <= -x_acc;
      mul_p2x <= {x_acc[A-2:0], 1'b0};
      mul_n2x <= -{x_acc[A-2:0], 1'b0};
      acc     <= '0;
      mq      <= y_ext;
      q_prev  <= 1'b0;
      cnt     <= '0;
    end else if (state == CALC) begin
      acc    <= acc_nxt;
      mq     <= mq_nxt;
      q_prev <= mq[1];
      cnt    <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z <= '0;
    end else if (last_iter) begin
      z <= z_nxt;
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

`default_nettype wire

// File: doc/booth_mul_param.md
BOOTH_MUL_PARAM -- requirements
Module: booth_mul_param

Interface
REQ-001 Parameter: WIDTH, default 16, operand width; SHALL be even and >= 4.
REQ-002 Derived constant: N = WIDTH/2 + 1, the number of radix-4 iterations.
REQ-003 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port: start, input, 1, request to begin a multiply.
REQ-006 Port: signed_mode, input, 1; 1 = x and y are two's complement, 0 = x and y are unsigned.
REQ-007 Port: x, input, WIDTH, multiplicand.
REQ-008 Port: y, input, WIDTH, multiplier.
REQ-009 Port: z, output, 2*WIDTH, registered product.
REQ-010 Port: busy, output, 1, high while a multiply is in progress.
REQ-011 Port: done, output, 1, single-cycle pulse marking that z has just been updated.

Function
REQ-012 The block SHALL use three states:
- IDLE: waiting for start.
- CALC: iterating.
- DONE: result cycle.
REQ-013 Accept: start=1 while in IDLE or DONE SHALL accept the request.
- x, y and signed_mode are sampled at that edge.
- The next state is CALC.
- start in any other state SHALL be ignored, with no effect on the operation in flight.
REQ-014 On accept, operands SHALL be extended to WIDTH+2 bits.
- signed_mode=1: sign extension.
- signed_mode=0: zero extension.
- This makes the unsigned full range exact.
REQ-015 Precomputed multiples: +X, -X, +2X and -2X SHALL be formed once on accept and held for the whole operation.
REQ-016 Each CALC cycle SHALL:
- decode one overlapping 3-bit Booth group (LSB first, implicit 0 below bit 0);
- add 0, +X, +2X, -2X or -X per the standard radix-4 table;
- arithmetic-shift the partial product right by 2.
REQ-017 The iteration counter SHALL count 0..N-1.
- CALC SHALL last exactly N cycles.
- After the N-th iteration the state SHALL become DONE.
REQ-018 On the edge leaving CALC, the block SHALL:
- load z with the low 2*WIDTH bits of the exact product;
- set done=1 for exactly the one DONE cycle.
REQ-019 Latency: done SHALL be high exactly N+1 cycles after the accept edge; for WIDTH=16 that is 10 cycles.
REQ-020 busy SHALL be 1 during all CALC cycles and 0 in IDLE and DONE.
REQ-021 DONE SHALL go to IDLE on the next edge unless start=1, in which case it goes to CALC (back-to-back throughput of one result per N+1 cycles).
REQ-022 Outside the DONE update, z SHALL hold its last value and change only on the edge leaving CALC.
REQ-023 Internal datapath width SHALL be sufficient that no overflow occurs for any operand pair in either mode, including most-negative times most-negative.
REQ-024 Changes on x, y or signed_mode after accept SHALL NOT affect the operation in flight.

Reset
REQ-025 rst_n=0 SHALL immediately, and independently of clk, force:
- state = IDLE;
- z = 0, busy = 0, done = 0;
- the counter and all internal registers = 0.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-027 After reset release, the first start SHALL behave as from power-up.

Verification (WIDTH=16 unless stated)
REQ-028 Signed min by min: signed_mode=1, x=0x8000, y=0x8000, start 1 cycle -> busy high 9 cycles, done pulses at cycle 10, z=0x40000000.
REQ-029 Unsigned max by max: signed_mode=0, x=0xFFFF, y=0xFFFF -> z=0xFFFE0001; same operands with signed_mode=1 -> z=0x00000001.
REQ-030 Mixed sign: signed_mode=1, x=0xFFFF (-1), y=0x0001 -> z=0xFFFFFFFF; then x=0x7FFF, y=0x8000 -> z=0xC0008000.
REQ-031 Start while busy: start held high through CALC with different x/y -> first result unaffected; start still high in the DONE cycle -> second operation accepted back-to-back, done exactly every 10 cycles.
REQ-032 Reset mid-op: rst_n low at CALC cycle 4 -> z=0, busy=0 immediately, no done pulse; a fresh 3x5 after release -> z=15.
REQ-033 Sweep with WIDTH=8: exhaustive x, y in both modes against a reference model -> every z exact, done latency 6 cycles, busy never high in IDLE.
